fan_pwm_ramp: RTL

- Consumes the 7-bit percent duty command from the fan speed-select stage (levels 0/30/60/90) and drives the fan motor PWM pin.
- Soft-ramps the applied duty toward the command, one percent at a time, to limit inrush and acoustic steps; a stop command (0) takes effect at the next PWM period boundary.
- Sits between the button/duty selector and the fan driver output pin.

---
 rtl/fan_pkg.sv | 33 +++
 rtl/fan_tick_gen.sv | 29 ++
 rtl/fan_pwm_ramp.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fan_pkg.sv
// Shared definitions for the fan control path: duty width, PWM resolution,
// the preset speed levels used by the speed-select stage, and a clamp helper.
package fan_pkg;

  localparam int DUTY_W    = 7;
  localparam int PWM_STEPS = 100;
  localparam int DUTY_MAX  = 100;

  typedef logic [DUTY_W-1:0] duty_t;

  localparam duty_t DUTY_OFF  = 7'd0;
  localparam duty_t DUTY_LOW  = 7'd30;
  localparam duty_t DUTY_MID  = 7'd60;
  localparam duty_t DUTY_HIGH = 7'd90;

  localparam duty_t DUTY_MAX_D  = duty_t'(DUTY_MAX);
  localparam duty_t PWM_LAST_D  = duty_t'(PWM_STEPS - 1);

  // What the ramp logic does with the applied duty at a period boundary.
  typedef enum logic [2:0] {
    ACT_IDLE,     // not a boundary cycle, nothing happens
    ACT_STOP,     // command is zero: drop to off immediately
    ACT_SETTLED,  // applied duty already equals the command
    ACT_COUNT,    // still waiting out the periods before the next 1% step
    ACT_STEP      // move the applied duty one percent toward the command
  } ramp_act_e;

  // A 7-bit command can encode up to 127; anything above full scale means full.
  function automatic duty_t clamp_duty(input duty_t d);
    return (d > DUTY_MAX_D) ? DUTY_MAX_D : d;
  endfunction

endpackage

// File: rtl/fan_tick_gen.sv
// Free-running prescaler: o_step_tick is high for one clock every DIV clocks,
// on the cycle the counter sits at DIV-1 (the counter wraps on that same cycle).
module fan_tick_gen #(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic i_reset_p,
  output logic o_step_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_presc;

  assign o_step_tick = (r_presc == LAST);

  // Count 0..DIV-1 and wrap on the tick cycle.
  always_ff @(posedge clk) begin
    if (i_reset_p) begin
      r_presc <= '0;
    end else if (o_step_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + CW'(1);
    end
  end

endmodule

// File: rtl/fan_pwm_ramp.sv
// Fan motor PWM with soft ramping. The command is sampled only at the PWM
// period boundary; the applied duty walks toward it by 1% every RAMP_PERIODS
// periods, except that a zero command stops the fan at once. Because the
// applied duty only moves at the boundary, every period has a single width.
// RAMP_PERIODS must be at least 1.
module fan_pwm_ramp
  import fan_pkg::*;
#(
  parameter int STEP_DIV     = 100,
  parameter int RAMP_PERIODS = 4
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm,
  output logic [DUTY_W-1:0] duty_now,
  output logic              period_tick,
  output logic              ramping
);

  localparam int RCW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [RCW-1:0] RC_LAST = RCW'(RAMP_PERIODS - 1);

  logic           w_step_tick;
  logic           w_boundary;
  duty_t          w_cmd;
  ramp_act_e      w_ramp_act;
  duty_t          w_duty_next;
  logic [RCW-1:0] w_ramp_cnt_next;

  duty_t          r_pwm_cnt;
  duty_t          r_target;
  duty_t          r_duty_now;
  logic [RCW-1:0] r_ramp_cnt;
  logic           r_pwm;
  logic           r_period_tick;
  logic           r_ramping;

  fan_tick_gen #(
    .DIV (STEP_DIV)
  ) u_tick_gen (
    .clk         (clk),
    .i_reset_p   (reset_p),
    .o_step_tick (w_step_tick)
  );

  // The last step of the last PWM slot is the period boundary.
  assign w_boundary = w_step_tick && (r_pwm_cnt == PWM_LAST_D);
  assign w_cmd      = clamp_duty(duty);

  // PWM slot counter, 0..99, advanced once per prescaler tick.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_pwm_cnt <= '0;
    end else if (w_step_tick) begin
      if (r_pwm_cnt == PWM_LAST_D) begin
        r_pwm_cnt <= '0;
      end else begin
        r_pwm_cnt <= r_pwm_cnt + 7'd1;
      end
    end
  end

  // Decide the boundary action from the freshly clamped command, then form
  // the next applied duty and ramp period count from it.
  always_comb begin
    w_ramp_act      = ACT_IDLE;
    w_duty_next     = r_duty_now;
    w_ramp_cnt_next = r_ramp_cnt;

    if (w_boundary) begin
      if (w_cmd == DUTY_OFF) begin
        w_ramp_act = ACT_STOP;
      end else if (w_cmd == r_duty_now) begin
        w_ramp_act = ACT_SETTLED;
      end else if (r_ramp_cnt == RC_LAST) begin
        w_ramp_act = ACT_STEP;
      end else begin
        w_ramp_act = ACT_COUNT;
      end
    end

    case (w_ramp_act)
      ACT_STOP: begin
        w_duty_next     = DUTY_OFF;
        w_ramp_cnt_next = '0;
      end
      ACT_SETTLED: begin
        w_ramp_cnt_next = '0;
      end
      ACT_STEP: begin
        // The command is never equal to the applied duty here, so the step
        // cannot overshoot it, and the command is bounded to 1..100.
        w_ramp_cnt_next = '0;
        if (w_cmd > r_duty_now) begin
          w_duty_next = r_duty_now + 7'd1;
        end else begin
          w_duty_next = r_duty_now - 7'd1;
        end
      end
      ACT_COUNT: begin
        w_ramp_cnt_next = r_ramp_cnt + RCW'(1);
      end
      default: begin
      end
    endcase
  end

  // Latch the target and apply the ramp decision; the ramp counter keeps
  // running across a retarget so the cadence does not restart.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_target      <= '0;
      r_duty_now    <= '0;
      r_ramp_cnt    <= '0;
      r_period_tick <= 1'b0;
    end else begin
      r_duty_now    <= w_duty_next;
      r_ramp_cnt    <= w_ramp_cnt_next;
      r_period_tick <= w_boundary;
      if (w_boundary) begin
        r_target <= w_cmd;
      end
    end
  end

  // Registered pin and status: compare slot against applied duty, flag any
  // remaining distance to the latched target.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_pwm     <= 1'b0;
      r_ramping <= 1'b0;
    end else begin
      r_pwm     <= (r_pwm_cnt < r_duty_now);
      r_ramping <= (r_duty_now != r_target);
    end
  end

  assign pwm         = r_pwm;
  assign duty_now    = r_duty_now;
  assign period_tick = r_period_tick;
  assign ramping     = r_ramping;

endmodule
